// File: rtl/life_step_engine.sv
// One Game-of-Life generation on a toroidal ROWS x COLS grid, evaluated one cell per clock.
// Optional LIFE_RESEED_EN: an extinct generation commits SEED instead and pulses extinct.
module life_step_engine #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter logic [ROWS*COLS-1:0] SEED = 100'h701002
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] cur_state,
  output logic [ROWS*COLS-1:0] next_state,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          gen_count
`ifdef LIFE_RESEED_EN
  ,
  output logic                 extinct
`endif
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMMIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [RW-1:0]      r_row;
  logic [CW-1:0]      r_col;
  logic [N-1:0]       r_snapshot;
  logic [N-1:0]       r_work;
  logic [N-1:0]       r_next_state;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_gen_count;

  logic [RW-1:0]      w_row_up;
  logic [RW-1:0]      w_row_dn;
  logic [CW-1:0]      w_col_lf;
  logic [CW-1:0]      w_col_rt;
  logic [RW-1:0]      w_nb_row [3];
  logic [CW-1:0]      w_nb_col [3];
  logic [3:0]         w_count;
  logic               w_alive;
  logic               w_cell_nxt;
  logic               w_last;
  logic [N-1:0]       w_commit_val;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [RW-1:0] row,
                                                input logic [CW-1:0] col);
    return IDX_W'(int'(row) * COLS + int'(col));
  endfunction

  // Toroidal neighbour coordinates from the running row/col counters
  assign w_row_up = (r_row == '0) ? RW'(ROWS - 1) : r_row - 1'b1;
  assign w_row_dn = (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
  assign w_col_lf = (r_col == '0) ? CW'(COLS - 1) : r_col - 1'b1;
  assign w_col_rt = (r_col == CW'(COLS - 1)) ? '0 : r_col + 1'b1;

  assign w_nb_row[0] = w_row_up;
  assign w_nb_row[1] = r_row;
  assign w_nb_row[2] = w_row_dn;
  assign w_nb_col[0] = w_col_lf;
  assign w_nb_col[1] = r_col;
  assign w_nb_col[2] = w_col_rt;

  always_comb begin
    w_count = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if (!(dr == 1 && dc == 1)) begin
          w_count = w_count + 4'(r_snapshot[cell_idx(w_nb_row[dr], w_nb_col[dc])]);
        end
      end
    end
  end

  assign w_alive    = r_snapshot[r_idx];
  assign w_cell_nxt = (w_count == 4'd3) | (w_alive & (w_count == 4'd2));
  assign w_last     = (r_idx == IDX_W'(N - 1));

`ifdef LIFE_RESEED_EN
  logic r_extinct;
  logic w_extinct;
  assign w_extinct    = (r_work == '0);
  assign w_commit_val = w_extinct ? SEED : r_work;
  assign extinct      = r_extinct;
`else
  logic w_unused_seed;
  assign w_commit_val  = r_work;
  assign w_unused_seed = ^SEED;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_RUN;
      S_RUN:    if (w_last) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_snapshot   <= '0;
      r_work       <= '0;
      r_next_state <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_gen_count  <= '0;
`ifdef LIFE_RESEED_EN
      r_extinct    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef LIFE_RESEED_EN
      r_extinct <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snapshot <= cur_state;
            r_idx      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_work[r_idx] <= w_cell_nxt;
          r_idx         <= r_idx + 1'b1;
          if (r_col == CW'(COLS - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_COMMIT: begin
          r_next_state <= w_commit_val;
          r_done       <= 1'b1;
          r_gen_count  <= r_gen_count + 16'd1;
          r_busy       <= 1'b0;
`ifdef LIFE_RESEED_EN
          r_extinct    <= w_extinct;
`endif
        end
        default: ;
      endcase
    end
  end

  assign next_state = r_next_state;
  assign busy       = r_busy;
  assign done       = r_done;
  assign gen_count  = r_gen_count;

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: directed patterns plus random grids against a behavioural Life model.
module tb_life_step_engine;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int N    = ROWS * COLS;
  localparam int IW   = 7;
  localparam logic [N-1:0] GLIDER = 100'h701002;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  cur_state = '0;
  logic [N-1:0]  next_state;
  logic          busy;
  logic          done;
  logic [15:0]   gen_count;
`ifdef LIFE_RESEED_EN
  logic          extinct;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int exp_gen = 0;

  life_step_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cur_state  (cur_state),
    .next_state (next_state),
    .busy       (busy),
    .done       (done),
    .gen_count  (gen_count)
`ifdef LIFE_RESEED_EN
    ,
    .extinct    (extinct)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] bit_at(input int i);
    logic [N-1:0] v;
    v = '0;
    v[IW'(i)] = 1'b1;
    return v;
  endfunction

  // Reference generation: straightforward modular neighbour count per cell
  function automatic logic [N-1:0] life_ref(input logic [N-1:0] g);
    logic [N-1:0] res;
    int cnt;
    logic alive;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              cnt += int'(g[IW'(((r + dr + ROWS) % ROWS) * COLS + ((c + dc + COLS) % COLS))]);
          end
        end
        alive = g[IW'(r * COLS + c)];
        res[IW'(r * COLS + c)] = (cnt == 3) || (alive && cnt == 2);
      end
    end
    return res;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt, output bit ok);
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    ok       = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      edges++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_gen = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_total++; if (next_state !== '0) $display("FAIL reset_next: got %h want 0", next_state); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (gen_count !== 16'd0) $display("FAIL reset_gen: got %0d want 0", gen_count); else n_pass++;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_and_start_busy: got %b want 0", busy); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL rst_and_start_busy_later: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_blinker;
    int edges, bcnt;
    bit ok;
    logic [N-1:0] horiz, vert;
    horiz = bit_at(44) | bit_at(45) | bit_at(46);
    vert  = bit_at(35) | bit_at(45) | bit_at(55);
    cur_state = horiz;
    pulse_start();
    wait_done(edges, bcnt, ok);
    exp_gen++;
    n_total++; if (!ok) $display("FAIL blinker_done_seen: got none want pulse"); else n_pass++;
    n_total++; if (edges != 101) $display("FAIL blinker_latency: got %0d want 101", edges); else n_pass++;
    n_total++; if (bcnt != 101) $display("FAIL blinker_busy_cycles: got %0d want 101", bcnt); else n_pass++;
    n_total++; if (next_state !== vert) $display("FAIL blinker_next: got %h want %h", next_state, vert); else n_pass++;
    n_total++; if (gen_count !== 16'(exp_gen)) $display("FAIL blinker_gen: got %0d want %0d", gen_count, exp_gen); else n_pass++;
`ifdef LIFE_RESEED_EN
    n_total++; if (extinct !== 1'b0) $display("FAIL blinker_extinct: got %b want 0", extinct); else n_pass++;
`endif
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL blinker_done_width: got %b want 0", done); else n_pass++;
    cur_state = vert;
    pulse_start();
    wait_done(edges, bcnt, ok);
    exp_gen++;
    n_total++; if (!ok) $display("FAIL blinker2_done_seen: got none want pulse"); else n_pass++;
    n_total++; if (next_state !== horiz) $display("FAIL blinker2_next: got %h want %h", next_state, horiz); else n_pass++;
    n_total++; if (gen_count !== 16'(exp_gen)) $display("FAIL blinker2_gen: got %0d want %0d", gen_count, exp_gen); else n_pass++;
  endtask

  task automatic test_wrap_block;
    int edges, bcnt;
    bit ok;
    logic [N-1:0] blk;
    blk = bit_at(0) | bit_at(9) | bit_at(90) | bit_at(99);
    cur_state = blk;
    pulse_start();
    wait_done(edges, bcnt, ok);
    exp_gen++;
    n_total++; if (!ok) $display("FAIL wrap_done_seen: got none want pulse"); else n_pass++;
    n_total++; if (next_state !== blk) $display("FAIL wrap_next: got %h want %h", next_state, blk); else n_pass++;
    n_total++; if (next_state[1] !== 1'b0) $display("FAIL wrap_cell1: got %b want 0", next_state[1]); else n_pass++;
  endtask

  task automatic test_start_while_busy;
    int edges, bcnt, done_edge, rebusy_edge, dcount;
    bit ok;
    logic [N-1:0] vert;
    vert = bit_at(35) | bit_at(45) | bit_at(55);
    cur_state = bit_at(44) | bit_at(45) | bit_at(46);
    done_edge = -1;
    rebusy_edge = -1;
    dcount = 0;
    start = 1'b1;
    tick();
    for (int e = 1; e < 150; e++) begin
      tick();
      if (done) begin
        dcount++;
        if (done_edge < 0) done_edge = e;
      end
      if (done_edge > 0 && e > done_edge && busy && rebusy_edge < 0) rebusy_edge = e;
    end
    start = 1'b0;
    n_total++; if (done_edge != 101) $display("FAIL held_done_edge: got %0d want 101", done_edge); else n_pass++;
    n_total++; if (rebusy_edge != 102) $display("FAIL held_restart_edge: got %0d want 102", rebusy_edge); else n_pass++;
    n_total++; if (dcount != 1) $display("FAIL held_done_count: got %0d want 1", dcount); else n_pass++;
    wait_done(edges, bcnt, ok);
    exp_gen += 2;
    n_total++; if (edges != 54) $display("FAIL held_second_latency: got %0d want 54", edges); else n_pass++;
    n_total++; if (next_state !== vert) $display("FAIL held_next: got %h want %h", next_state, vert); else n_pass++;
    n_total++; if (gen_count !== 16'(exp_gen)) $display("FAIL held_gen: got %0d want %0d", gen_count, exp_gen); else n_pass++;

    do_reset();
    dcount = 0;
    pulse_start();
    for (int e = 1; e <= 250; e++) begin
      start = (e == 10 || e == 100);
      tick();
      start = 1'b0;
      if (done) dcount++;
    end
    exp_gen++;
    n_total++; if (dcount != 1) $display("FAIL pulsed_done_count: got %0d want 1", dcount); else n_pass++;
    n_total++; if (gen_count !== 16'(exp_gen)) $display("FAIL pulsed_gen: got %0d want %0d", gen_count, exp_gen); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int edges, bcnt, dcount;
    bit ok;
    logic [N-1:0] exp;
    cur_state = bit_at(44) | bit_at(45) | bit_at(46);
    dcount = 0;
    pulse_start();
    for (int e = 1; e < 50; e++) begin
      tick();
      if (done) dcount++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_gen = 0;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (next_state !== '0) $display("FAIL midrst_next: got %h want 0", next_state); else n_pass++;
    n_total++; if (gen_count !== 16'd0) $display("FAIL midrst_gen: got %0d want 0", gen_count); else n_pass++;
    for (int e = 0; e < 120; e++) begin
      tick();
      if (done) dcount++;
    end
    n_total++; if (dcount != 0) $display("FAIL midrst_no_done: got %0d want 0", dcount); else n_pass++;
    // Glider advances one phase: shape moves down and flips
    exp = bit_at(10) | bit_at(12) | bit_at(21) | bit_at(22) | bit_at(31);
    cur_state = GLIDER;
    pulse_start();
    wait_done(edges, bcnt, ok);
    exp_gen++;
    n_total++; if (!ok) $display("FAIL glider_done_seen: got none want pulse"); else n_pass++;
    n_total++; if (next_state !== exp) $display("FAIL glider_next: got %h want %h", next_state, exp); else n_pass++;
    n_total++; if (gen_count !== 16'(exp_gen)) $display("FAIL glider_gen: got %0d want %0d", gen_count, exp_gen); else n_pass++;
  endtask

  task automatic test_extinction;
    int edges, bcnt;
    bit ok;
    logic [N-1:0] exp;
`ifdef LIFE_RESEED_EN
    exp = GLIDER;
`else
    exp = '0;
`endif
    cur_state = bit_at(55);
    pulse_start();
    wait_done(edges, bcnt, ok);
    exp_gen++;
    n_total++; if (!ok) $display("FAIL extinct_done_seen: got none want pulse"); else n_pass++;
    n_total++; if (next_state !== exp) $display("FAIL extinct_next: got %h want %h", next_state, exp); else n_pass++;
    n_total++; if (gen_count !== 16'(exp_gen)) $display("FAIL extinct_gen: got %0d want %0d", gen_count, exp_gen); else n_pass++;
`ifdef LIFE_RESEED_EN
    n_total++; if (extinct !== 1'b1) $display("FAIL extinct_pulse: got %b want 1", extinct); else n_pass++;
    tick();
    n_total++; if (extinct !== 1'b0) $display("FAIL extinct_width: got %b want 0", extinct); else n_pass++;
`endif
  endtask

  task automatic test_input_isolation;
    int edges, bcnt;
    bit ok;
    logic [N-1:0] vert;
    vert = bit_at(35) | bit_at(45) | bit_at(55);
    cur_state = bit_at(44) | bit_at(45) | bit_at(46);
    pulse_start();
    tick();
    tick();
    tick();
    cur_state = '1;
    wait_done(edges, bcnt, ok);
    exp_gen++;
    n_total++; if (!ok) $display("FAIL isolate_done_seen: got none want pulse"); else n_pass++;
    n_total++; if (next_state !== vert) $display("FAIL isolate_next: got %h want %h", next_state, vert); else n_pass++;
  endtask

  task automatic test_random;
    int edges, bcnt;
    bit ok;
    logic [N-1:0] g, exp;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        g[IW'(i)] = (t % 2 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      exp = life_ref(g);
`ifdef LIFE_RESEED_EN
      if (exp == '0) exp = GLIDER;
`endif
      cur_state = g;
      pulse_start();
      wait_done(edges, bcnt, ok);
      exp_gen++;
      n_total++; if (!ok || edges != 101) $display("FAIL rand%0d_latency: got %0d want 101", t, edges); else n_pass++;
      n_total++; if (next_state !== exp) $display("FAIL rand%0d_next: got %h want %h", t, next_state, exp); else n_pass++;
      n_total++; if (gen_count !== 16'(exp_gen)) $display("FAIL rand%0d_gen: got %0d want %0d", t, gen_count, exp_gen); else n_pass++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_blinker();
    test_wrap_block();
    test_start_while_busy();
    test_reset_mid_run();
    test_extinction();
    test_input_isolation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
